// File: rtl/mux_select_arbiter.sv
// Round-robin owner arbiter for a shared N:1 mux select, with optional hold-limit
// preemption and a mandatory one-cycle gnt=0 turnaround between owners.
module mux_select_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int SEL_W    = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               preempt
);

    localparam int HC_W = $clog2(MAX_HOLD + 2);
    localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [SEL_W-1:0]   sel_n, last, last_n, pick;
    logic               busy_n, preempt_n, others;
    logic [HC_W-1:0]    hold_cnt, hold_n;

    // First requester after 'base', wrapping modulo NUM_REQ; base itself is scanned last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [SEL_W-1:0]   base);
        logic [SEL_W-1:0] p;
        logic             found;
        int               idx;
        p     = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(base) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && r[idx]) begin
                p     = idx[SEL_W-1:0];
                found = 1'b1;
            end
        end
        return p;
    endfunction

    assign pick   = rr_pick(req, last);
    assign others = |(req & ~gnt);

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        sel_n     = sel;
        busy_n    = busy;
        preempt_n = 1'b0;
        hold_n    = hold_cnt;
        last_n    = last;
        case (state)
            GRANT: begin
                if (!req[sel]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                end else if (MAX_HOLD > 0 && hold_cnt >= HOLD_LAST && others) begin
                    // >= rather than == so a requester arriving after saturation still gets in
                    state_n   = GAP;
                    gnt_n     = '0;
                    busy_n    = 1'b0;
                    preempt_n = 1'b1;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                if (|req) begin
                    state_n = GRANT;
                    gnt_n   = NUM_REQ'(1) << pick;
                    sel_n   = pick;
                    busy_n  = 1'b1;
                    last_n  = pick;
                    hold_n  = '0;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
            hold_cnt <= '0;
            last     <= SEL_W'(NUM_REQ - 1);
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
            busy     <= busy_n;
            preempt  <= preempt_n;
            hold_cnt <= hold_n;
            last     <= last_n;
        end
    end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Bench for mux_select_arbiter: directed scenarios on a 2-requester instance and
// round-robin plus randomized model comparison on a 4-requester instance.
module tb_mux_select_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req2 = '0, gnt2;
    logic       sel2, busy2, pre2;
    logic [3:0] req4 = '0, gnt4;
    logic [1:0] sel4;
    logic       busy4, pre4;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mux_select_arbiter #(.NUM_REQ(2), .SEL_W(1), .MAX_HOLD(16)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .gnt(gnt2), .sel(sel2), .busy(busy2), .preempt(pre2)
    );

    mux_select_arbiter #(.NUM_REQ(4), .SEL_W(2), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .gnt(gnt4), .sel(sel4), .busy(busy4), .preempt(pre4)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req2 = '0; req4 = '0;
        tick(); tick();
        checks++;
        if ({gnt2, sel2, busy2, pre2} !== 5'b0)
            $display("FAIL reset2: got %b expected %b", {gnt2, sel2, busy2, pre2}, 5'b0);
        else passes++;
        checks++;
        if ({gnt4, sel4, busy4, pre4} !== 8'b0)
            $display("FAIL reset4: got %b expected %b", {gnt4, sel4, busy4, pre4}, 8'b0);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_preempt();
        logic [4:0] exp;
        req2 = 2'b11;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c <= 16)      exp = {2'b01, 1'b0, 1'b1, 1'b0};
            else if (c == 17) exp = {2'b00, 1'b0, 1'b0, 1'b1};
            else              exp = {2'b10, 1'b1, 1'b1, 1'b0};
            checks++;
            if ({gnt2, sel2, busy2, pre2} !== exp)
                $display("FAIL preempt c%0d: got %b expected %b", c, {gnt2, sel2, busy2, pre2}, exp);
            else passes++;
        end
        req2 = 2'b00;
        tick();
        checks++;
        if ({gnt2, sel2, busy2, pre2} !== 5'b00_1_0_0)
            $display("FAIL preempt_release: got %b expected %b", {gnt2, sel2, busy2, pre2}, 5'b00100);
        else passes++;
    endtask

    task automatic test_single();
        req2 = 2'b10;
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++;
            if ({gnt2, sel2, busy2, pre2} !== 5'b10_1_1_0)
                $display("FAIL single c%0d: got %b expected %b", c, {gnt2, sel2, busy2, pre2}, 5'b10110);
            else passes++;
        end
        req2 = 2'b00;
        tick();
        checks++;
        if ({gnt2, sel2, busy2, pre2} !== 5'b00_1_0_0)
            $display("FAIL single_drop: got %b expected %b", {gnt2, sel2, busy2, pre2}, 5'b00100);
        else passes++;
    endtask

    task automatic test_release_vs_new();
        req2 = 2'b01;
        tick(); tick();
        checks++;
        if ({gnt2, sel2, busy2, pre2} !== 5'b01_0_1_0)
            $display("FAIL rvn_grant0: got %b expected %b", {gnt2, sel2, busy2, pre2}, 5'b01010);
        else passes++;
        req2 = 2'b10;
        tick();
        checks++;
        if ({gnt2, sel2, busy2, pre2} !== 5'b00_0_0_0)
            $display("FAIL rvn_gap: got %b expected %b", {gnt2, sel2, busy2, pre2}, 5'b00000);
        else passes++;
        tick();
        checks++;
        if ({gnt2, sel2, busy2, pre2} !== 5'b10_1_1_0)
            $display("FAIL rvn_grant1: got %b expected %b", {gnt2, sel2, busy2, pre2}, 5'b10110);
        else passes++;
        req2 = 2'b00;
        tick();
    endtask

    task automatic test_drop_on_preempt();
        rst = 1'b1; tick(); rst = 1'b0;
        req2 = 2'b11;
        for (int c = 1; c <= 16; c++) begin
            tick();
            checks++;
            if ({gnt2, sel2, busy2, pre2} !== 5'b01_0_1_0)
                $display("FAIL drop_hold c%0d: got %b expected %b", c, {gnt2, sel2, busy2, pre2}, 5'b01010);
            else passes++;
        end
        req2 = 2'b10;
        tick();
        checks++;
        if ({gnt2, sel2, busy2, pre2} !== 5'b00_0_0_0)
            $display("FAIL drop_release: got %b expected %b", {gnt2, sel2, busy2, pre2}, 5'b00000);
        else passes++;
        tick();
        checks++;
        if ({gnt2, sel2, busy2, pre2} !== 5'b10_1_1_0)
            $display("FAIL drop_next: got %b expected %b", {gnt2, sel2, busy2, pre2}, 5'b10110);
        else passes++;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; req2 = 2'b11;
        tick();
        checks++;
        if ({gnt2, sel2, busy2, pre2} !== 5'b00_0_0_0)
            $display("FAIL rst_mid: got %b expected %b", {gnt2, sel2, busy2, pre2}, 5'b00000);
        else passes++;
        rst = 1'b0;
        tick();
        checks++;
        if ({gnt2, sel2, busy2, pre2} !== 5'b01_0_1_0)
            $display("FAIL rst_first: got %b expected %b", {gnt2, sel2, busy2, pre2}, 5'b01010);
        else passes++;
        req2 = 2'b00;
        tick();
    endtask

    task automatic test_round_robin();
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp;
        logic [3:0] oh;
        rst = 1'b1; tick(); rst = 1'b0;
        req4 = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << order[n];
            for (int c = 1; c <= 3; c++) begin
                tick();
                exp = {oh, 2'(order[n]), 1'b1, 1'b0};
                checks++;
                if ({gnt4, sel4, busy4, pre4} !== exp)
                    $display("FAIL rr n%0d c%0d: got %b expected %b", n, c, {gnt4, sel4, busy4, pre4}, exp);
                else passes++;
            end
            req4 = 4'b1111 & ~oh;
            tick();
            exp = {4'b0000, 2'(order[n]), 1'b0, 1'b0};
            checks++;
            if ({gnt4, sel4, busy4, pre4} !== exp)
                $display("FAIL rr_gap n%0d: got %b expected %b", n, {gnt4, sel4, busy4, pre4}, exp);
            else passes++;
            req4 = 4'b1111;
        end
        req4 = 4'b0000;
        tick();
    endtask

    // Reference: owner index (-1 = none), cycles granted so far, last winner.
    task automatic test_random();
        int         owner = -1, len = 0, last = 3, msel = 0, idx;
        bit         mpre = 1'b0, rr;
        logic [3:0] r, egnt;
        logic [7:0] exp;
        rst = 1'b1; req4 = '0; tick(); rst = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            r = req4;
            if ($urandom_range(3) == 0) begin
                idx = int'($urandom_range(3));
                r[idx] = ~r[idx];
            end
            rr   = ($urandom_range(59) == 0);
            rst  = rr;
            req4 = r;
            @(posedge clk);
            mpre = 1'b0;
            if (rr) begin
                owner = -1; len = 0; last = 3; msel = 0;
            end else if (owner >= 0) begin
                if (!r[owner]) owner = -1;
                else if (len >= 4 && (r & ~(4'b0001 << owner)) != 4'b0) begin
                    owner = -1; mpre = 1'b1;
                end else len++;
            end else if (r != 4'b0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (r[(last + k) % 4]) begin
                        owner = (last + k) % 4;
                        break;
                    end
                end
                last = owner; msel = owner; len = 1;
            end
            @(negedge clk);
            egnt = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
            exp  = {egnt, 2'(msel), owner >= 0, mpre};
            checks++;
            if ({gnt4, sel4, busy4, pre4} !== exp)
                $display("FAIL random c%0d req=%b: got %b expected %b", cyc, r, {gnt4, sel4, busy4, pre4}, exp);
            else passes++;
        end
        rst = 1'b0; req4 = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_preempt();
        test_single();
        test_release_vs_new();
        test_drop_on_preempt();
        test_reset_mid();
        test_round_robin();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
